pga_agc_ctrl: RTL and testbench

//  Automatic gain control sequencer for the MCP6S91 PGA control block. Measures peak |sample| of the
//  ADC stream over a fixed window and steps the 3-bit PGA gain up/down one code per window.

---
 rtl/pga_agc_pkg.sv | 18 +
 rtl/pga_agc_ctrl_peak.sv | 49 ++++
 rtl/pga_agc_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pga_agc_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pga_agc_pkg.sv
// Shared types for the MCP6S91 PGA automatic gain control sequencer.
package pga_agc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQUEST   = 3'd1,
    WAIT_DONE = 3'd2,
    SETTLE    = 3'd3,
    MEASURE   = 3'd4,
    DECIDE    = 3'd5
  } agc_state_t;

  typedef logic [2:0] pga_gain_t;

  localparam pga_gain_t GAIN_MIN = 3'd0;
  localparam pga_gain_t GAIN_MAX = 3'd7;

endpackage

// File: rtl/pga_agc_ctrl_peak.sv
// Running peak of |Sample| over a measurement window; the most negative code saturates to max.
module pga_agc_ctrl_peak #(
  parameter int SampleWidth = 12
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          Clear,
  input  logic                          Valid,
  input  logic signed [SampleWidth-1:0] Sample,
  output logic        [SampleWidth-2:0] RunPeak
);

  localparam int PW = SampleWidth - 1;

  logic [PW-1:0] peak_r;
  logic [PW-1:0] mag_s;

  function automatic logic [PW-1:0] absSat(input logic signed [SampleWidth-1:0] s);
    if (!s[SampleWidth-1]) begin
      absSat = s[PW-1:0];
    end else if (s[PW-1:0] == {PW{1'b0}}) begin
      absSat = {PW{1'b1}};
    end else begin
      absSat = ~s[PW-1:0] + {{(PW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Peak including the sample presented this cycle, so the window end can capture it.
  always_comb begin
    mag_s = absSat(Sample);
    if (Valid && (mag_s > peak_r)) begin
      RunPeak = mag_s;
    end else begin
      RunPeak = peak_r;
    end
  end

  // Peak register; clear wins over an arriving sample.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      peak_r <= {PW{1'b0}};
    end else if (Clear) begin
      peak_r <= {PW{1'b0}};
    end else if (Valid) begin
      peak_r <= RunPeak;
    end
  end

endmodule

// File: rtl/pga_agc_ctrl.sv
// AGC sequencer driving the PGA Int/Gain/Done handshake from a windowed sample peak.
// Optional Done timeout with sticky Fault enabled by defining PGA_AGC_TIMEOUT_EN.
module pga_agc_ctrl
  import pga_agc_pkg::*;
#(
  parameter int        SampleWidth   = 12,
  parameter int        WindowLen     = 1024,
  parameter int        HighThresh    = 1536,
  parameter int        LowThresh     = 256,
  parameter int        SettleCycles  = 4096,
  parameter pga_gain_t InitGain      = 3'd0,
  parameter int        TimeoutCycles = 65535
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          Enable,
  input  logic signed [SampleWidth-1:0] Sample,
  input  logic                          SampleValid,
  output logic                          PgaInt,
  output logic        [2:0]             PgaGain,
  input  logic                          PgaDone,
  output logic        [2:0]             CurGain,
  output logic        [SampleWidth-2:0] Peak,
  output logic                          Busy,
  output logic                          Fault
);

  localparam int PW   = SampleWidth - 1;
  localparam int WinW = $clog2(WindowLen + 1);
  localparam int SetW = $clog2(SettleCycles + 1);

  agc_state_t      state_r;
  logic            pgaInt_r;
  pga_gain_t       pgaGain_r;
  pga_gain_t       curGain_r;
  logic [PW-1:0]   peak_r;
  logic            busy_r;
  logic [WinW-1:0] winCnt_r;
  logic [SetW-1:0] setCnt_r;

  logic            peakValid_s;
  logic            peakClear_s;
  logic            winLast_s;
  logic [PW-1:0]   runPeak_s;

`ifdef PGA_AGC_TIMEOUT_EN
  localparam int ToW = $clog2(TimeoutCycles + 1);
  logic [ToW-1:0] toCnt_r;
  logic           fault_r;
  assign Fault = fault_r;
`else
  assign Fault = 1'b0;
  // TimeoutCycles only matters with the timeout build; keep it referenced for a uniform interface.
  if (TimeoutCycles < 1) begin : gTimeoutUnused
  end
`endif

  // Samples only count in MEASURE; the peak accumulator is held clear everywhere else.
  always_comb begin
    peakValid_s = (state_r == MEASURE) && SampleValid;
    winLast_s   = peakValid_s && (winCnt_r == WinW'(WindowLen - 1));
    peakClear_s = (state_r != MEASURE) || winLast_s;
  end

  pga_agc_ctrl_peak #(
    .SampleWidth(SampleWidth)
  ) uPeak (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .Clear  (peakClear_s),
    .Valid  (peakValid_s),
    .Sample (Sample),
    .RunPeak(runPeak_s)
  );

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= IDLE;
      pgaInt_r  <= 1'b0;
      pgaGain_r <= InitGain;
      curGain_r <= InitGain;
      peak_r    <= {PW{1'b0}};
      busy_r    <= 1'b0;
      winCnt_r  <= {WinW{1'b0}};
      setCnt_r  <= {SetW{1'b0}};
`ifdef PGA_AGC_TIMEOUT_EN
      toCnt_r   <= {ToW{1'b0}};
      fault_r   <= 1'b0;
`endif
    end else begin
      pgaInt_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Enable) begin
            pgaGain_r <= InitGain;
            pgaInt_r  <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= REQUEST;
          end
        end
        REQUEST: begin
`ifdef PGA_AGC_TIMEOUT_EN
          toCnt_r <= {ToW{1'b0}};
`endif
          state_r <= WAIT_DONE;
        end
        // Enable is deliberately ignored: an interrupted write would restart the PGA frame.
        WAIT_DONE: begin
          if (PgaDone) begin
            curGain_r <= pgaGain_r;
            setCnt_r  <= {SetW{1'b0}};
            state_r   <= SETTLE;
          end
`ifdef PGA_AGC_TIMEOUT_EN
          else if (toCnt_r == ToW'(TimeoutCycles - 1)) begin
            fault_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            toCnt_r <= toCnt_r + ToW'(1);
          end
`endif
        end
        SETTLE: begin
          if (!Enable) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (setCnt_r == SetW'(SettleCycles - 1)) begin
            winCnt_r <= {WinW{1'b0}};
            state_r  <= MEASURE;
          end else begin
            setCnt_r <= setCnt_r + SetW'(1);
          end
        end
        MEASURE: begin
          if (!Enable) begin
            winCnt_r <= {WinW{1'b0}};
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end else if (winLast_s) begin
            peak_r   <= runPeak_s;
            winCnt_r <= {WinW{1'b0}};
            state_r  <= DECIDE;
          end else if (peakValid_s) begin
            winCnt_r <= winCnt_r + WinW'(1);
          end
        end
        DECIDE: begin
          if ((peak_r > PW'(HighThresh)) && (curGain_r > GAIN_MIN)) begin
            pgaGain_r <= curGain_r - 3'd1;
            pgaInt_r  <= 1'b1;
            state_r   <= REQUEST;
          end else if ((peak_r < PW'(LowThresh)) && (curGain_r < GAIN_MAX)) begin
            pgaGain_r <= curGain_r + 3'd1;
            pgaInt_r  <= 1'b1;
            state_r   <= REQUEST;
          end else begin
            state_r <= MEASURE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign PgaInt  = pgaInt_r;
  assign PgaGain = pgaGain_r;
  assign CurGain = curGain_r;
  assign Peak    = peak_r;
  assign Busy    = busy_r;

endmodule

// File: tb/tb_pga_agc_ctrl.sv
// Directed bench for pga_agc_ctrl (WindowLen=4, SettleCycles=8, InitGain=2, TimeoutCycles=20).
module tb_pga_agc_ctrl;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              Enable;
  logic signed [11:0] Sample;
  logic              SampleValid;
  logic              PgaInt;
  logic [2:0]        PgaGain;
  logic              PgaDone;
  logic [2:0]        CurGain;
  logic [10:0]       Peak;
  logic              Busy;
  logic              Fault;

  int errors = 0;
  int checks = 0;

`ifdef PGA_AGC_TIMEOUT_EN
  localparam int LongDelay = 15;
`else
  localparam int LongDelay = 500;
`endif

  always #5 Clk = ~Clk;

  pga_agc_ctrl #(
    .SampleWidth  (12),
    .WindowLen    (4),
    .HighThresh   (1536),
    .LowThresh    (256),
    .SettleCycles (8),
    .InitGain     (3'd2),
    .TimeoutCycles(20)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Enable     (Enable),
    .Sample     (Sample),
    .SampleValid(SampleValid),
    .PgaInt     (PgaInt),
    .PgaGain    (PgaGain),
    .PgaDone    (PgaDone),
    .CurGain    (CurGain),
    .Peak       (Peak),
    .Busy       (Busy),
    .Fault      (Fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic watchNoInt(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (PgaInt === 1'b1) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic doDone(input int d);
    repeat (d) tick();
    PgaDone = 1'b1;
    tick();
    PgaDone = 1'b0;
  endtask

  // Runs the 8-cycle settle; valid samples offered early in it must be discarded.
  task automatic settle();
    Sample      = -12'sd2000;
    SampleValid = 1'b1;
    repeat (6) tick();
    SampleValid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic sendWindow(input logic signed [11:0] a, input logic signed [11:0] b,
                            input logic signed [11:0] c, input logic signed [11:0] d);
    Sample = a; SampleValid = 1'b1; tick();
    Sample = b; tick();
    Sample = c; tick();
    Sample = d; tick();
    SampleValid = 1'b0;
  endtask

  task automatic expectReq(input string tag, input logic [2:0] g);
    check({tag, "_lat1"}, PgaInt, 1'b0);
    tick();
    check({tag, "_int"}, PgaInt, 1'b1);
    check({tag, "_gain"}, PgaGain, g);
    tick();
    check({tag, "_int1cyc"}, PgaInt, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; Enable = 1'b0; Sample = 12'sd0; SampleValid = 1'b0; PgaDone = 1'b0;
    repeat (3) tick();
    check("rst_int", PgaInt, 1'b0);
    check("rst_gain", PgaGain, 3'd2);
    check("rst_cur", CurGain, 3'd2);
    check("rst_peak", Peak, 11'd0);
    check("rst_busy", Busy, 1'b0);
    check("rst_fault", Fault, 1'b0);

    Reset_n = 1'b1;
    watchNoInt("idle_no_int", 2);
    check("idle_busy", Busy, 1'b0);

    // First write after enable
    Enable = 1'b1;
    tick();
    check("en_int", PgaInt, 1'b1);
    check("en_gain", PgaGain, 3'd2);
    check("en_busy", Busy, 1'b1);
    tick();
    check("en_int1cyc", PgaInt, 1'b0);
    doDone(9);
    check("en_cur", CurGain, 3'd2);
    check("en_busy2", Busy, 1'b1);
    settle();

    // Saturated negative full scale -> peak 2047, gain down
    sendWindow(12'sd100, -12'sd2048, 12'sd0, 12'sd5);
    check("wA_peak", Peak, 11'd2047);
    expectReq("wA", 3'd1);
    doDone(3);
    check("wA_cur", CurGain, 3'd1);
    settle();

    // Quiet windows step the gain up to the top code
    for (int g = 2; g <= 7; g++) begin
      sendWindow(12'sd10, -12'sd10, 12'sd10, 12'sd10);
      check($sformatf("up%0d_peak", g), Peak, 11'd10);
      expectReq($sformatf("up%0d", g), g[2:0]);
      doDone(2);
      check($sformatf("up%0d_cur", g), CurGain, g);
      settle();
    end

    // At gain 7 a quiet window must not write
    sendWindow(12'sd10, 12'sd10, 12'sd10, 12'sd10);
    check("max_peak", Peak, 11'd10);
    watchNoInt("max_no_int", 4);
    check("max_cur", CurGain, 3'd7);

    // Peak exactly at the high threshold: no change
    sendWindow(12'sd1536, -12'sd1536, 12'sd1536, 12'sd1536);
    check("eq_peak", Peak, 11'd1536);
    watchNoInt("eq_no_int", 4);
    check("eq_cur", CurGain, 3'd7);

    // Peak carried by the final sample; then enable dropped during a long write
    sendWindow(12'sd100, 12'sd200, 12'sd300, 12'sd2000);
    check("dn_peak", Peak, 11'd2000);
    expectReq("dn", 3'd6);
    Enable = 1'b0;
    watchNoInt("drop_no_int", LongDelay);
    check("drop_gain_hold", PgaGain, 3'd6);
    check("drop_busy", Busy, 1'b1);
    PgaDone = 1'b1;
    tick();
    PgaDone = 1'b0;
    check("drop_cur", CurGain, 3'd6);
    watchNoInt("drop_after", 3);
    check("drop_idle", Busy, 1'b0);

    // Stray Done in IDLE ignored
    PgaDone = 1'b1;
    tick();
    PgaDone = 1'b0;
    tick();
    check("stray_cur", CurGain, 3'd6);
    check("stray_busy", Busy, 1'b0);

    Enable = 1'b1;
    tick();
    check("re_int", PgaInt, 1'b1);
    check("re_gain", PgaGain, 3'd2);
`ifdef PGA_AGC_TIMEOUT_EN
    repeat (20) tick();
    check("to_early", Fault, 1'b0);
    tick();
    check("to_fault", Fault, 1'b1);
    check("to_busy", Busy, 1'b0);
    check("to_cur", CurGain, 3'd6);
    tick();
    check("to_reint", PgaInt, 1'b1);
    check("to_sticky", Fault, 1'b1);
`endif
    tick();
    doDone(2);
    check("re_cur", CurGain, 3'd2);
    settle();

    sendWindow(-12'sd1500, 12'sd1700, 12'sd0, 12'sd0);
    check("wB_peak", Peak, 11'd1700);
    expectReq("wB", 3'd1);
    doDone(2);
    check("wB_cur", CurGain, 3'd1);
    settle();

    // Async reset in the middle of a window
    Sample = 12'sd50; SampleValid = 1'b1;
    repeat (2) tick();
    Reset_n = 1'b0;
    #2;
    check("ar_int", PgaInt, 1'b0);
    check("ar_gain", PgaGain, 3'd2);
    check("ar_cur", CurGain, 3'd2);
    check("ar_peak", Peak, 11'd0);
    check("ar_busy", Busy, 1'b0);
    check("ar_fault", Fault, 1'b0);
    SampleValid = 1'b0;
    Enable = 1'b0;
    watchNoInt("ar_hold", 3);
    Reset_n = 1'b1;
    watchNoInt("ar_release", 3);
    Enable = 1'b1;
    tick();
    check("ar_reprog_int", PgaInt, 1'b1);
    check("ar_reprog_gain", PgaGain, 3'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
